// File: rtl/ball_centroid.sv
// Per-frame blob centroid from the colour-filter pixel write stream.
// Accumulates hit count and coordinate sums, then divides serially at frame end.
module ball_centroid #(
    parameter int c_img_cols    = 80,
    parameter int c_img_rows    = 60,
    parameter int c_img_pxls    = 4800,
    parameter int c_nb_img_pxls = 13,
    parameter int c_nb_buf      = 12,
    parameter int c_min_pxls    = 16,
    parameter int c_nb_sum      = 19
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pxl_we,
    input  logic [c_nb_img_pxls-1:0] pxl_addr,
    input  logic [c_nb_buf-1:0]      pxl_data,
    output logic [6:0]               cent_col,
    output logic [5:0]               cent_row,
    output logic                     found,
    output logic                     cent_valid,
    output logic                     busy,
    output logic                     overrun,
    output logic [7:0]               leds
);

    localparam int c_nb_col  = 7;
    localparam int c_nb_row  = 6;
    localparam int c_nb_cnt  = c_nb_img_pxls;
    localparam int c_nb_iter = $clog2(c_nb_sum);

    typedef enum logic [1:0] {
        ST_ACC,
        ST_DIV,
        ST_DONE
    } state_t;

    state_t state_reg, state_next;

    logic [c_nb_col-1:0]  col_reg;
    logic [c_nb_row-1:0]  row_reg;
    logic [c_nb_cnt-1:0]  cnt_reg;
    logic [c_nb_sum-1:0]  sum_x_reg;
    logic [c_nb_sum-1:0]  sum_y_reg;
    logic [c_nb_cnt-1:0]  dcnt_reg;
    logic [c_nb_iter-1:0] iter_reg;

    logic [c_nb_col-1:0]  cent_col_reg;
    logic [c_nb_row-1:0]  cent_row_reg;
    logic                 found_reg;
    logic                 cent_valid_reg;
    logic                 overrun_reg;
    logic [7:0]           leds_reg;

    logic                 resync;
    logic                 frame_end;
    logic                 hit;
    logic                 latch;
    logic [c_nb_col-1:0]  pix_col;
    logic [c_nb_row-1:0]  pix_row;
    logic [c_nb_col-1:0]  col_adv;
    logic [c_nb_row-1:0]  row_adv;
    logic [c_nb_cnt-1:0]  cnt_acc;
    logic [c_nb_sum-1:0]  sum_x_acc;
    logic [c_nb_sum-1:0]  sum_y_acc;
    logic [c_nb_sum-1:0]  dividend [2];
    logic [c_nb_col-1:0]  quo_col;
    logic [c_nb_row-1:0]  quo_row;
    logic                 found_now;
    logic [2:0]           band;

    // An accepted pixel at address 0 restarts the frame with itself as the only contribution.
    always_comb begin
        resync    = pxl_we && (pxl_addr == '0);
        frame_end = pxl_we && (pxl_addr == c_nb_img_pxls'(c_img_pxls - 1));
        hit       = (pxl_data != '0);
        latch     = frame_end && (state_reg != ST_DIV);

        pix_col   = resync ? '0 : col_reg;
        pix_row   = resync ? '0 : row_reg;
        cnt_acc   = (resync ? '0 : cnt_reg) + c_nb_cnt'(hit);
        sum_x_acc = (resync ? '0 : sum_x_reg) + (hit ? c_nb_sum'(pix_col) : '0);
        sum_y_acc = (resync ? '0 : sum_y_reg) + (hit ? c_nb_sum'(pix_row) : '0);

        col_adv = pix_col + 1'b1;
        row_adv = pix_row;
        if (pix_col == c_nb_col'(c_img_cols - 1)) begin
            col_adv = '0;
            row_adv = (pix_row == c_nb_row'(c_img_rows - 1)) ? '0 : pix_row + 1'b1;
        end

        dividend[0] = sum_x_acc;
        dividend[1] = sum_y_acc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_reg   <= '0;
            row_reg   <= '0;
            cnt_reg   <= '0;
            sum_x_reg <= '0;
            sum_y_reg <= '0;
        end else if (pxl_we) begin
            col_reg <= col_adv;
            row_reg <= row_adv;
            if (frame_end) begin
                cnt_reg   <= '0;
                sum_x_reg <= '0;
                sum_y_reg <= '0;
            end else begin
                cnt_reg   <= cnt_acc;
                sum_x_reg <= sum_x_acc;
                sum_y_reg <= sum_y_acc;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_ACC;
            iter_reg  <= '0;
            dcnt_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (latch) begin
                iter_reg <= '0;
                dcnt_reg <= cnt_acc;
            end else if (state_reg == ST_DIV) begin
                iter_reg <= iter_reg + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_ACC:  if (latch) state_next = ST_DIV;
            ST_DIV:  if (iter_reg == c_nb_iter'(c_nb_sum - 1)) state_next = ST_DONE;
            ST_DONE: state_next = latch ? ST_DIV : ST_ACC;
            default: state_next = ST_ACC;
        endcase
    end

    // Two identical restoring dividers (x, y); quotient shifts in where the dividend shifts out.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gen_div
            logic [c_nb_sum-1:0] quo_reg;
            logic [c_nb_cnt-1:0] rem_reg;
            logic [c_nb_cnt:0]   rem_shift;
            logic                q_bit;

            always_comb begin
                rem_shift = {rem_reg, quo_reg[c_nb_sum-1]};
                q_bit     = (rem_shift >= {1'b0, dcnt_reg});
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    quo_reg <= '0;
                    rem_reg <= '0;
                end else if (latch) begin
                    quo_reg <= dividend[gi];
                    rem_reg <= '0;
                end else if (state_reg == ST_DIV) begin
                    quo_reg <= {quo_reg[c_nb_sum-2:0], q_bit};
                    rem_reg <= q_bit ? (rem_shift[c_nb_cnt-1:0] - dcnt_reg)
                                     : rem_shift[c_nb_cnt-1:0];
                end
            end

            if (gi == 0) begin : gen_col
                assign quo_col = quo_reg[c_nb_col-1:0];
            end else begin : gen_row
                assign quo_row = quo_reg[c_nb_row-1:0];
            end
        end
    endgenerate

    always_comb begin
        found_now = (dcnt_reg >= c_nb_cnt'(c_min_pxls));
        band      = 3'(quo_col / 7'd10);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cent_col_reg   <= '0;
            cent_row_reg   <= '0;
            found_reg      <= 1'b0;
            cent_valid_reg <= 1'b0;
            overrun_reg    <= 1'b0;
            leds_reg       <= '0;
        end else begin
            cent_valid_reg <= 1'b0;
            if (frame_end && (state_reg == ST_DIV)) begin
                overrun_reg <= 1'b1;
            end
            if (state_reg == ST_DONE) begin
                cent_valid_reg <= 1'b1;
                found_reg      <= found_now;
                cent_col_reg   <= found_now ? quo_col : '0;
                cent_row_reg   <= found_now ? quo_row : '0;
                leds_reg       <= found_now ? (8'h80 >> band) : 8'h00;
            end
        end
    end

    assign cent_col   = cent_col_reg;
    assign cent_row   = cent_row_reg;
    assign found      = found_reg;
    assign cent_valid = cent_valid_reg;
    assign busy       = (state_reg == ST_DIV);
    assign overrun    = overrun_reg;
    assign leds       = leds_reg;

endmodule

// File: tb/tb_ball_centroid.sv
// Bench for ball_centroid: table of frame patterns plus hand-written corner sequences,
// two instances (default threshold and threshold 1) checked against a frame-level model.
module tb_ball_centroid;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pxl_we = 1'b0;
    logic [12:0] pxl_addr = '0;
    logic [11:0] pxl_data = '0;

    logic [6:0] cc0, cc1;
    logic [5:0] cr0, cr1;
    logic       fd0, fd1, cv0, cv1, bz0, bz1, ov0, ov1;
    logic [7:0] ld0, ld1;

    ball_centroid dut (
        .clk(clk), .rst(rst), .pxl_we(pxl_we), .pxl_addr(pxl_addr), .pxl_data(pxl_data),
        .cent_col(cc0), .cent_row(cr0), .found(fd0), .cent_valid(cv0),
        .busy(bz0), .overrun(ov0), .leds(ld0)
    );

    ball_centroid #(.c_min_pxls(1)) dut_min1 (
        .clk(clk), .rst(rst), .pxl_we(pxl_we), .pxl_addr(pxl_addr), .pxl_data(pxl_data),
        .cent_col(cc1), .cent_row(cr1), .found(fd1), .cent_valid(cv1),
        .busy(bz1), .overrun(ov1), .leds(ld1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int col;
        int row;
        int found;
        int leds;
    } res_t;

    res_t q0[$];
    res_t q1[$];

    always @(negedge clk) begin
        if (cv0) q0.push_back('{cyc, int'(cc0), int'(cr0), int'(fd0), int'(ld0)});
        if (cv1) q1.push_back('{cyc, int'(cc1), int'(cr1), int'(fd1), int'(ld1)});
    end

    typedef struct {
        int kind;      // 0 zero, 1 box, 2 corner pixel, 3 random
        int nhits;     // random: exact hit count, <0 means ~30% density
        int gaps;
        int e_found, e_col, e_row, e_leds;
        int e1_found, e1_col, e1_row, e1_leds;
    } vec_t;

    vec_t vecs [7];
    int   errors = 0;
    int   checks = 0;
    bit   hits [4800];
    int   fe_cyc;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            pxl_we   = 1'b0;
            pxl_addr = 13'($urandom_range(0, 4799));
            pxl_data = 12'($urandom);
        end
    endtask

    task automatic drive_px(input int addr, input bit hit, input int gaps);
        if (gaps != 0) begin
            while ($urandom_range(0, 3) == 0) idle(1);
        end
        @(negedge clk);
        pxl_we   = 1'b1;
        pxl_addr = 13'(addr);
        pxl_data = hit ? 12'($urandom_range(1, 4095)) : 12'h000;
        if (addr == 4799) fe_cyc = cyc + 1;
    endtask

    task automatic send_frame(input int gaps);
        for (int i = 0; i < 4800; i++) drive_px(i, hits[i], gaps);
    endtask

    task automatic fill(input int kind, input int nhits);
        int placed;
        int p;
        for (int i = 0; i < 4800; i++) begin
            case (kind)
                1:       hits[i] = (i % 80 >= 40) && (i % 80 <= 49) && (i / 80 >= 10) && (i / 80 <= 19);
                2:       hits[i] = (i == 4799);
                3:       hits[i] = (nhits < 0) ? ($urandom_range(0, 9) < 3) : 1'b0;
                default: hits[i] = 1'b0;
            endcase
        end
        placed = 0;
        if (kind == 3) begin
            while (placed < nhits) begin
                p = $urandom_range(0, 4799);
                if (!hits[p]) begin
                    hits[p] = 1'b1;
                    placed++;
                end
            end
        end
    endtask

    // Centroid straight from the hit map: floor mean of column and row indices.
    task automatic model(input int minp, output int f, output int c, output int r, output int l);
        int n, sx, sy;
        n = 0; sx = 0; sy = 0;
        for (int i = 0; i < 4800; i++) begin
            if (hits[i]) begin
                n++;
                sx += i % 80;
                sy += i / 80;
            end
        end
        f = (n >= minp) ? 1 : 0;
        c = f ? sx / n : 0;
        r = f ? sy / n : 0;
        l = f ? (128 >> (c / 10)) : 0;
    endtask

    task automatic check_result(input int which, input int fe, input string tag,
                                input int ef, input int ec, input int er, input int el);
        res_t r;
        int   k;
        int   sz;
        k  = 0;
        sz = (which == 0) ? q0.size() : q1.size();
        while (k < 200 && sz == 0) begin
            @(negedge clk);
            k++;
            sz = (which == 0) ? q0.size() : q1.size();
        end
        if (sz == 0) begin
            chk($sformatf("%s dut%0d cent_valid timeout(1=seen)", tag, which), 0, 1);
            return;
        end
        if (which == 0) r = q0.pop_front();
        else            r = q1.pop_front();
        $display("%s dut%0d: col=%0d row=%0d found=%0d leds=%02h latency=%0d",
                 tag, which, r.col, r.row, r.found, r.leds, r.cyc - fe);
        chk($sformatf("%s dut%0d latency", tag, which), r.cyc - fe, 20);
        chk($sformatf("%s dut%0d found", tag, which), r.found, ef);
        chk($sformatf("%s dut%0d col", tag, which), r.col, ec);
        chk($sformatf("%s dut%0d row", tag, which), r.row, er);
        chk($sformatf("%s dut%0d leds", tag, which), r.leds, el);
    endtask

    initial begin
        int ef, ec, er, el, ef1, ec1, er1, el1;
        int fe_a, fe_b;

        vecs[0] = '{0,  0, 0,  0,  0,  0, 0,  0,  0,  0, 0};
        vecs[1] = '{1,  0, 0,  1, 44, 14, 8,  1, 44, 14, 8};
        vecs[2] = '{2,  0, 0,  0,  0,  0, 0,  1, 79, 59, 1};
        vecs[3] = '{1,  0, 1,  1, 44, 14, 8,  1, 44, 14, 8};
        vecs[4] = '{3, -1, 1,  0,  0,  0, 0,  0,  0,  0, 0};
        vecs[5] = '{3, 15, 0,  0,  0,  0, 0,  0,  0,  0, 0};
        vecs[6] = '{3, 16, 1,  0,  0,  0, 0,  0,  0,  0, 0};

        repeat (3) @(negedge clk);
        chk("reset col", int'(cc0), 0);
        chk("reset row", int'(cr0), 0);
        chk("reset found", int'(fd0), 0);
        chk("reset valid", int'(cv0), 0);
        chk("reset busy", int'(bz0), 0);
        chk("reset leds", int'(ld0), 0);
        rst = 1'b0;
        idle(2);

        for (int v = 0; v < 7; v++) begin
            fill(vecs[v].kind, vecs[v].nhits);
            if (vecs[v].kind == 3) begin
                model(16, ef, ec, er, el);
                model(1, ef1, ec1, er1, el1);
            end else begin
                ef  = vecs[v].e_found;  ec  = vecs[v].e_col;  er  = vecs[v].e_row;  el  = vecs[v].e_leds;
                ef1 = vecs[v].e1_found; ec1 = vecs[v].e1_col; er1 = vecs[v].e1_row; el1 = vecs[v].e1_leds;
            end
            send_frame(vecs[v].gaps);
            fe_a = fe_cyc;
            idle(1);
            chk($sformatf("vec%0d busy in div", v), int'(bz0), 1);
            check_result(0, fe_a, $sformatf("vec%0d", v), ef, ec, er, el);
            check_result(1, fe_a, $sformatf("vec%0d", v), ef1, ec1, er1, el1);
            chk($sformatf("vec%0d busy after", v), int'(bz0), 0);
        end

        // Back-to-back frames: box then all-zero
        fill(1, 0);
        send_frame(0);
        fe_a = fe_cyc;
        fill(0, 0);
        send_frame(0);
        fe_b = fe_cyc;
        idle(1);
        check_result(0, fe_a, "b2b first", 1, 44, 14, 8);
        check_result(1, fe_a, "b2b first", 1, 44, 14, 8);
        check_result(0, fe_b, "b2b second", 0, 0, 0, 0);
        check_result(1, fe_b, "b2b second", 0, 0, 0, 0);
        chk("b2b overrun", int'(ov0), 0);

        // Frame end injected while dividing
        fill(1, 0);
        send_frame(0);
        fe_a = fe_cyc;
        idle(3);
        chk("inject busy", int'(bz0), 1);
        drive_px(4799, 1'b1, 0);
        idle(1);
        chk("inject overrun dut0", int'(ov0), 1);
        chk("inject overrun dut1", int'(ov1), 1);
        check_result(0, fe_a, "inject", 1, 44, 14, 8);
        check_result(1, fe_a, "inject", 1, 44, 14, 8);
        idle(40);
        chk("dropped frame extra valids", q0.size() + q1.size(), 0);

        // Reset five cycles into the division
        fill(1, 0);
        send_frame(0);
        idle(5);
        chk("prerst busy", int'(bz0), 1);
        rst = 1'b1;
        #1;
        chk("midrst col", int'(cc0), 0);
        chk("midrst row", int'(cr0), 0);
        chk("midrst leds", int'(ld0), 0);
        chk("midrst busy", int'(bz0), 0);
        chk("midrst overrun", int'(ov0), 0);
        idle(2);
        rst = 1'b0;
        idle(40);
        chk("midrst no valid", q0.size() + q1.size(), 0);
        $display("reset mid-division: valids after reset=%0d", q0.size() + q1.size());

        // Partial frame, then resync at address 0
        for (int i = 0; i < 2437; i++) drive_px(i, 1'b1, 0);
        fill(3, 16);
        hits[0] = 1'b1;
        model(16, ef, ec, er, el);
        model(1, ef1, ec1, er1, el1);
        send_frame(1);
        fe_a = fe_cyc;
        idle(1);
        check_result(0, fe_a, "resync", ef, ec, er, el);
        check_result(1, fe_a, "resync", ef1, ec1, er1, el1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
